// File: rtl/mem_pkg.sv
// mem_pkg: op encodings, bus size codes and FSM states shared by the MEM stage.
package mem_pkg;
    typedef enum logic [3:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LBU  = 4'd2,
        MEMOP_LH   = 4'd3,
        MEMOP_LHU  = 4'd4,
        MEMOP_LW   = 4'd5,
        MEMOP_LWL  = 4'd6,
        MEMOP_LWR  = 4'd7,
        MEMOP_SB   = 4'd8,
        MEMOP_SH   = 4'd9,
        MEMOP_SW   = 4'd10
    } mem_op_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    function automatic logic is_load(input mem_op_e op);
        return op >= MEMOP_LB && op <= MEMOP_LWR;
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return op >= MEMOP_SB && op <= MEMOP_SW;
    endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: picks, shifts and extends load data by op and byte offset; builds the writeback byte mask.
module load_align
    import mem_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  strb
);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;

    assign sh = rdata >> {off, 3'b000};
    assign b  = sh[7:0];
    assign h  = off[1] ? rdata[31:16] : rdata[15:0];

    // LWL fills from the top byte down, LWR from the bottom byte up
    always_comb begin
        wdata = rdata;
        strb  = 4'b1111;
        case (op)
            MEMOP_LB:  wdata = {{24{b[7]}}, b};
            MEMOP_LBU: wdata = {24'b0, b};
            MEMOP_LH:  wdata = {{16{h[15]}}, h};
            MEMOP_LHU: wdata = {16'b0, h};
            MEMOP_LWL: begin
                wdata = rdata << {~off, 3'b000};
                strb  = 4'b1111 << ~off;
            end
            MEMOP_LWR: begin
                wdata = sh;
                strb  = 4'b1111 >> off;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage; issues loads/stores on the SRAM-like bus and stalls until the ack.
// MEM_ALIGN_CHECK_EN adds address-error outputs and suppresses misaligned accesses.
module mem_stage
    import mem_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MEM_in_valid,
    input  logic [OP_W-1:0] MEM_in_op,
    input  logic [31:0]     MEM_in_addr,
    input  logic [31:0]     MEM_in_store_data,
    input  logic [31:0]     MEM_in_alu_result,
    input  logic [4:0]      MEM_in_RF_waddr,
    input  logic            MEM_in_RF_wen,
    input  logic [31:0]     MEM_in_PC,
    output logic            data_req,
    output logic            data_wr,
    output logic [1:0]      data_size,
    output logic [31:0]     data_addr,
    output logic [3:0]      data_wstrb,
    output logic [31:0]     data_wdata,
    input  logic            data_addr_ok,
    input  logic            data_data_ok,
    input  logic [31:0]     data_rdata,
    output logic [31:0]     MEM_out_RF_wdata,
    output logic [4:0]      MEM_out_RF_waddr,
    output logic [3:0]      MEM_out_RF_strb,
    output logic            MEM_out_RF_wen,
    output logic [31:0]     MEM_out_PC,
    output logic            MEM_stall
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic            MEM_out_adel,
    output logic            MEM_out_ades,
    output logic [31:0]     MEM_out_badvaddr
`endif
);
    state_e      state, state_nx;
    mem_op_e     op;
    logic        op_ok, load, store, misalign, mem_op;
    logic [31:0] la_wdata;
    logic [3:0]  la_strb;

    assign op_ok = MEM_in_op >= OP_W'(1) && MEM_in_op <= OP_W'(10);
    assign op    = op_ok ? mem_op_e'(MEM_in_op[3:0]) : MEMOP_NONE;
    assign load  = is_load(op);
    assign store = is_store(op);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = ((op == MEMOP_LH || op == MEMOP_LHU || op == MEMOP_SH) && MEM_in_addr[0]) ||
                      ((op == MEMOP_LW || op == MEMOP_SW) && MEM_in_addr[1:0] != 2'b00);
    assign MEM_out_adel     = MEM_in_valid & load & misalign;
    assign MEM_out_ades     = MEM_in_valid & store & misalign;
    assign MEM_out_badvaddr = MEM_in_addr;
`else
    assign misalign = 1'b0;
`endif

    assign mem_op = MEM_in_valid & (load | store) & ~misalign;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // a request in flight during reset is dropped; the memory side resets alongside
    always_comb begin
        state_nx  = state;
        data_req  = 1'b0;
        MEM_stall = mem_op & ~((state == S_WAIT) & data_data_ok);
        case (state)
            S_IDLE: begin
                data_req = mem_op & ~rst;
                state_nx = mem_op ? (data_addr_ok ? S_WAIT : S_REQ) : S_IDLE;
            end
            S_REQ: begin
                data_req = ~rst;
                state_nx = data_addr_ok ? S_WAIT : S_REQ;
            end
            S_WAIT:  state_nx = data_data_ok ? S_IDLE : S_WAIT;
            default: state_nx = S_IDLE;
        endcase
    end

    assign data_wr    = store;
    assign data_size  = (op == MEMOP_LB || op == MEMOP_LBU || op == MEMOP_SB) ? SIZE_BYTE :
                        (op == MEMOP_LH || op == MEMOP_LHU || op == MEMOP_SH) ? SIZE_HALF : SIZE_WORD;
    assign data_addr  = (op == MEMOP_LWL || op == MEMOP_LWR) ? {MEM_in_addr[31:2], 2'b00} : MEM_in_addr;
    assign data_wstrb = op == MEMOP_SB ? 4'b0001 << MEM_in_addr[1:0] :
                        op == MEMOP_SH ? 4'b0011 << {MEM_in_addr[1], 1'b0} :
                        op == MEMOP_SW ? 4'b1111 : 4'b0000;
    assign data_wdata = op == MEMOP_SB ? {4{MEM_in_store_data[7:0]}} :
                        op == MEMOP_SH ? {2{MEM_in_store_data[15:0]}} : MEM_in_store_data;

    load_align u_load_align (
        .op    (op),
        .off   (MEM_in_addr[1:0]),
        .rdata (data_rdata),
        .wdata (la_wdata),
        .strb  (la_strb)
    );

    assign MEM_out_RF_wdata = load ? la_wdata : MEM_in_alu_result;
    assign MEM_out_RF_strb  = load ? la_strb : 4'b1111;
    assign MEM_out_RF_wen   = MEM_in_valid & MEM_in_RF_wen & ~misalign;
    assign MEM_out_RF_waddr = MEM_in_RF_waddr;
    assign MEM_out_PC       = MEM_in_PC;
endmodule
